// File: rtl/rseq_sequencer.sv
// Micro-op sequencer: walks a combinational micro-code ROM from a per-type entry
// address and hands registered micro-op words to a consumer with valid/ready flow control.
module rseq_sequencer #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 5,
    parameter int SEQ_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    input  logic [SEQ_W-1:0]  start_type,
    output logic              start_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_oe,
    input  logic [DATA_W-1:0] rom_data,
    output logic              uop_valid,
    output logic [DATA_W-1:0] uop_data,
    input  logic              uop_ready,
    output logic              busy,
    output logic              seq_done,
    output logic              overrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] TAIL = 2'd2;

    localparam logic [ADDR_W-1:0] UPC_TOP = '1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] upc;
    logic [ADDR_W-1:0] entry_addr;
    logic [DATA_W-1:0] cap_word;
    logic              start_accept;
    logic              consume;
    logic              capture;
    logic              at_top;
    logic              cap_last;

    assign start_ready  = (state == IDLE) && !flush;
    assign start_accept = start_valid && start_ready;
    assign consume      = uop_valid && uop_ready;
    assign capture      = (state == RUN) && (!uop_valid || uop_ready) && !flush;
    assign at_top       = (upc == UPC_TOP);
    assign cap_last     = rom_data[DATA_W-1];
    assign entry_addr   = ADDR_W'(start_type) << (ADDR_W - SEQ_W);

    assign rom_oe   = (state == RUN);
    assign rom_addr = rom_oe ? upc : '0;
    assign busy     = (state != IDLE);
    assign seq_done = (state == TAIL) && consume && !flush;

    // A word captured at the top address is terminated artificially so the
    // consumer still sees a properly closed sequence.
    always_comb begin
        // NOTE: default first so every path assigns cap_word and no latch is inferred.
        cap_word             = rom_data;
        cap_word[DATA_W-1]   = rom_data[DATA_W-1] | at_top;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            upc       <= '0;
            uop_valid <= 1'b0;
            uop_data  <= '0;
            overrun   <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            uop_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (consume) uop_valid <= 1'b0;
                    if (start_accept) begin
                        upc     <= entry_addr;
                        overrun <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (capture) begin
                        uop_data  <= cap_word;
                        uop_valid <= 1'b1;
                        // upc saturates at the top so a runaway sequence never wraps to 0.
                        if (!at_top) upc <= upc + 1'b1;
                        if (at_top && !cap_last) overrun <= 1'b1;
                        if (at_top || cap_last) state <= TAIL;
                    end
                end
                TAIL: begin
                    if (consume) begin
                        uop_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rseq_sequencer.sv
// Directed bench for rseq_sequencer: per-cycle vector table for the main sequences,
// plus hand-written reset-abort and reduced-parameter sequences.
module tb_rseq_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic [1:0]   start_type;
    logic         start_ready;
    logic         flush;
    logic [4:0]   rom_addr;
    logic         rom_oe;
    logic [127:0] rom_data;
    logic         uop_valid;
    logic [127:0] uop_data;
    logic         uop_ready;
    logic         busy;
    logic         seq_done;
    logic         overrun;

    logic         s2_start_valid;
    logic         s2_start_type;
    logic         s2_start_ready;
    logic         s2_flush;
    logic [2:0]   s2_rom_addr;
    logic         s2_rom_oe;
    logic [63:0]  s2_rom_data;
    logic         s2_uop_valid;
    logic [63:0]  s2_uop_data;
    logic         s2_uop_ready;
    logic         s2_busy;
    logic         s2_seq_done;
    logic         s2_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rseq_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_type(start_type), .start_ready(start_ready),
        .flush(flush), .rom_addr(rom_addr), .rom_oe(rom_oe), .rom_data(rom_data),
        .uop_valid(uop_valid), .uop_data(uop_data), .uop_ready(uop_ready),
        .busy(busy), .seq_done(seq_done), .overrun(overrun)
    );

    rseq_sequencer #(.DATA_W(64), .ADDR_W(3), .SEQ_W(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .start_valid(s2_start_valid), .start_type(s2_start_type), .start_ready(s2_start_ready),
        .flush(s2_flush), .rom_addr(s2_rom_addr), .rom_oe(s2_rom_oe), .rom_data(s2_rom_data),
        .uop_valid(s2_uop_valid), .uop_data(s2_uop_data), .uop_ready(s2_uop_ready),
        .busy(s2_busy), .seq_done(s2_seq_done), .overrun(s2_overrun)
    );

    // ROM images: LAST on words 2, 10, 17 (none in 24..31); small ROM LAST on word 6.
    function automatic logic [127:0] rom_word(input logic [4:0] a);
        logic [127:0] w;
        w          = '0;
        w[31:0]    = 32'hC0DE_0000 | 32'(a);
        w[127]     = (a == 5'd2) || (a == 5'd10) || (a == 5'd17);
        return w;
    endfunction

    function automatic logic [63:0] rom2_word(input logic [2:0] a);
        logic [63:0] w;
        w       = '0;
        w[31:0] = 32'hB0B0_0000 | 32'(a);
        w[63]   = (a == 3'd6);
        return w;
    endfunction

    always_comb rom_data    = rom_oe ? rom_word(rom_addr) : '0;
    always_comb s2_rom_data = s2_rom_oe ? rom2_word(s2_rom_addr) : '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         sv;
        logic [1:0]   st;
        logic         fl;
        logic         rdy;
        logic         sr;
        logic         bsy;
        logic         oe;
        logic [4:0]   addr;
        logic         uv;
        logic [127:0] data;
        logic         done;
        logic         ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic sv, input logic [1:0] st, input logic fl, input logic rdy,
                       input logic sr, input logic bsy, input logic oe, input logic [4:0] addr,
                       input logic uv, input logic [127:0] data, input logic done, input logic ovr);
        vec_t v;
        v.sv = sv; v.st = st; v.fl = fl; v.rdy = rdy;
        v.sr = sr; v.bsy = bsy; v.oe = oe; v.addr = addr;
        v.uv = uv; v.data = data; v.done = done; v.ovr = ovr;
        vecs.push_back(v);
    endtask

    task automatic fill_table();
        logic [127:0] w31_forced;
        w31_forced      = rom_word(5'd31);
        w31_forced[127] = 1'b1;
        // Type 1, consumer always ready: words 8, 9, 10 back to back.
        add(1, 1, 0, 1,  1, 0, 0, 0,  0, 0,            0, 0);
        add(0, 0, 0, 1,  0, 1, 1, 8,  0, 0,            0, 0);
        add(0, 0, 0, 1,  0, 1, 1, 9,  1, rom_word(8),  0, 0);
        add(0, 0, 0, 1,  0, 1, 1, 10, 1, rom_word(9),  0, 0);
        add(0, 0, 0, 1,  0, 1, 0, 0,  1, rom_word(10), 1, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0,  0, 0,            0, 0);
        // Type 1 with a 3-cycle stall on word 8, then a stall in TAIL.
        add(1, 1, 0, 1,  1, 0, 0, 0,  0, 0,            0, 0);
        add(0, 0, 0, 1,  0, 1, 1, 8,  0, 0,            0, 0);
        add(0, 0, 0, 0,  0, 1, 1, 9,  1, rom_word(8),  0, 0);
        add(0, 0, 0, 0,  0, 1, 1, 9,  1, rom_word(8),  0, 0);
        add(0, 0, 0, 0,  0, 1, 1, 9,  1, rom_word(8),  0, 0);
        add(0, 0, 0, 1,  0, 1, 1, 9,  1, rom_word(8),  0, 0);
        add(0, 0, 0, 1,  0, 1, 1, 10, 1, rom_word(9),  0, 0);
        add(0, 0, 0, 0,  0, 1, 0, 0,  1, rom_word(10), 0, 0);
        add(0, 0, 0, 1,  0, 1, 0, 0,  1, rom_word(10), 1, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0,  0, 0,            0, 0);
        // Type 3 runs off the top of the ROM without LAST.
        add(1, 3, 0, 1,  1, 0, 0, 0,  0, 0,            0, 0);
        add(0, 0, 0, 1,  0, 1, 1, 24, 0, 0,            0, 0);
        for (int k = 2; k <= 8; k++)
            add(0, 0, 0, 1, 0, 1, 1, 5'(23 + k), 1, rom_word(5'(22 + k)), 0, 0);
        add(0, 0, 0, 1,  0, 1, 0, 0,  1, w31_forced,   1, 1);
        add(0, 0, 0, 1,  1, 0, 0, 0,  0, 0,            0, 1);
        // Next accepted start clears overrun; flush while word 9 is presented.
        add(1, 1, 0, 1,  1, 0, 0, 0,  0, 0,            0, 1);
        add(0, 0, 0, 1,  0, 1, 1, 8,  0, 0,            0, 0);
        add(0, 0, 0, 1,  0, 1, 1, 9,  1, rom_word(8),  0, 0);
        add(1, 1, 1, 1,  0, 1, 1, 10, 1, rom_word(9),  0, 0);
        add(1, 1, 1, 1,  0, 0, 0, 0,  0, 0,            0, 0);
        add(0, 0, 0, 1,  1, 0, 0, 0,  0, 0,            0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_valid = 1'b0; start_type = '0; flush = 1'b0; uop_ready = 1'b0;
        s2_start_valid = 1'b0; s2_start_type = 1'b0; s2_flush = 1'b0; s2_uop_ready = 1'b1;
        fill_table();

        repeat (2) @(negedge clk);
        check("rst busy",    busy, 0);
        check("rst uv",      uop_valid, 0);
        check("rst data",    uop_data, 0);
        check("rst oe",      rom_oe, 0);
        check("rst addr",    rom_addr, 0);
        check("rst ovr",     overrun, 0);
        check("rst done",    seq_done, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            start_valid = vecs[i].sv; start_type = vecs[i].st;
            flush = vecs[i].fl; uop_ready = vecs[i].rdy;
            #1;
            check($sformatf("v%0d start_ready", i), start_ready, vecs[i].sr);
            check($sformatf("v%0d busy", i),        busy,        vecs[i].bsy);
            check($sformatf("v%0d rom_oe", i),      rom_oe,      vecs[i].oe);
            check($sformatf("v%0d rom_addr", i),    rom_addr,    vecs[i].addr);
            check($sformatf("v%0d uop_valid", i),   uop_valid,   vecs[i].uv);
            if (vecs[i].uv)
                check($sformatf("v%0d uop_data", i), uop_data,   vecs[i].data);
            check($sformatf("v%0d seq_done", i),    seq_done,    vecs[i].done);
            check($sformatf("v%0d overrun", i),     overrun,     vecs[i].ovr);
        end

        // Asynchronous reset in the middle of a type-2 sequence.
        @(negedge clk); start_valid = 1'b1; start_type = 2'd2; flush = 1'b0; uop_ready = 1'b1;
        @(negedge clk); start_valid = 1'b0;
        @(negedge clk); #1;
        check("pre-rst uv",   uop_valid, 1);
        check("pre-rst data", uop_data, rom_word(16));
        #1 rst_n = 1'b0;
        #1;
        check("arst busy",  busy, 0);
        check("arst uv",    uop_valid, 0);
        check("arst data",  uop_data, 0);
        check("arst oe",    rom_oe, 0);
        check("arst addr",  rom_addr, 0);
        check("arst done",  seq_done, 0);
        check("arst sr",    start_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        start_valid = 1'b1; start_type = 2'd0;
        #1 check("t0 accept sr", start_ready, 1);
        @(negedge clk); start_valid = 1'b0; #1;
        check("t0 oe",   rom_oe, 1);
        check("t0 addr", rom_addr, 0);
        @(negedge clk); #1;
        check("t0 w0", uop_data, rom_word(0));
        check("t0 uv", uop_valid, 1);
        @(negedge clk); #1;
        check("t0 w1", uop_data, rom_word(1));
        @(negedge clk); #1;
        check("t0 w2",   uop_data, rom_word(2));
        check("t0 done", seq_done, 1);
        @(negedge clk); #1;
        check("t0 idle", busy, 0);

        // Reduced parameters: type 1 enters at address 4, LAST from bit 63.
        @(negedge clk); s2_start_valid = 1'b1; s2_start_type = 1'b1;
        #1 check("p2 sr", s2_start_ready, 1);
        @(negedge clk); s2_start_valid = 1'b0; #1;
        check("p2 oe",   s2_rom_oe, 1);
        check("p2 addr", s2_rom_addr, 4);
        @(negedge clk); #1;
        check("p2 w4",    s2_uop_data, rom2_word(4));
        check("p2 addr5", s2_rom_addr, 5);
        @(negedge clk); #1;
        check("p2 w5",    s2_uop_data, rom2_word(5));
        @(negedge clk); #1;
        check("p2 w6",    s2_uop_data, rom2_word(6));
        check("p2 last",  s2_uop_data[63], 1);
        check("p2 done",  s2_seq_done, 1);
        check("p2 ovr",   s2_overrun, 0);
        @(negedge clk); #1;
        check("p2 idle sr", s2_start_ready, 1);
        check("p2 busy",    s2_busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
